epl_column_access_seq: RTL and testbench

//  Parametrised column-access sequencer between the word-level ECC/datapath and the bit-cell array.

---
 rtl/epl_column_access_seq_pkg.sv | 28 ++
 rtl/epl_column_access_seq_mux_map.sv | 30 +++
 rtl/epl_column_access_seq.sv | 175 +++++++++++++++++
 tb/tb_epl_column_access_seq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/epl_column_access_seq_pkg.sv
// Shared definitions for the column-access sequencer: request mode codes,
// FSM state encoding and the one-hot request check.
package epl_column_access_seq_pkg;

    localparam logic [1:0] MODE_WR    = 2'b00;
    localparam logic [1:0] MODE_RD    = 2'b01;
    localparam logic [1:0] MODE_BURST = 2'b10;
    localparam logic [1:0] MODE_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_BURST = 2'd2,
        ST_READ  = 2'd3
    } col_state_e;

    // Widest phase vector the one-hot check accepts; callers zero-extend.
    localparam int ONEHOT_MAX = 64;

    function automatic int column_count(input int tword_width, input int mux);
        return tword_width * mux;
    endfunction

    function automatic logic is_onehot(input logic [ONEHOT_MAX-1:0] v);
        return (v != '0) && ((v & (v - ONEHOT_MAX'(1))) == '0);
    endfunction

endpackage

// File: rtl/epl_column_access_seq_mux_map.sv
// Column-mux mapping: codeword bit i at phase k lives on column i*MUX+k.
// Scatters a codeword onto the column bus and gathers a word back from it.
module epl_col_mux_map #(
    parameter int TWORD_WIDTH = 8,
    parameter int MUX         = 4
) (
    input  logic [MUX-1:0]             phase,
    input  logic [TWORD_WIDTH-1:0]     codeword,
    input  logic [TWORD_WIDTH*MUX-1:0] col_in,
    output logic [TWORD_WIDTH*MUX-1:0] col_mask,
    output logic [TWORD_WIDTH*MUX-1:0] col_data,
    output logic [TWORD_WIDTH-1:0]     gather
);

    always_comb begin
        col_mask = '0;
        col_data = '0;
        gather   = '0;
        for (int i = 0; i < TWORD_WIDTH; i++) begin
            for (int k = 0; k < MUX; k++) begin
                if (phase[k]) begin
                    col_mask[i*MUX+k] = 1'b1;
                    col_data[i*MUX+k] = codeword[i];
                    gather[i]         = gather[i] | col_in[i*MUX+k];
                end
            end
        end
    end

endmodule

// File: rtl/epl_column_access_seq.sv
// Column-access sequencer: accepts write / read / burst-write requests and
// drives timed per-column enables toward the bit-cell array.
module epl_column_access_seq
    import epl_column_access_seq_pkg::*;
#(
    parameter int TWORD_WIDTH = 8,
    parameter int MUX         = 4,
    parameter int WE_CYCLES   = 2,
    parameter int RD_LAT      = 2
) (
    input  logic                       pClk_i,
    input  logic                       nRst_i,
    input  logic                       pValid_i,
    output logic                       pReady_o,
    input  logic [1:0]                 pMode_i,
    input  logic [MUX-1:0]             pAcy_i,
    input  logic [TWORD_WIDTH-1:0]     pCodeword_i,
    output logic [TWORD_WIDTH*MUX-1:0] pWe_o,
    output logic [TWORD_WIDTH*MUX-1:0] pDi_o,
    output logic [TWORD_WIDTH*MUX-1:0] pRe_o,
    input  logic [TWORD_WIDTH*MUX-1:0] pDo_i,
    output logic [TWORD_WIDTH-1:0]     pRdata_o,
    output logic                       pRvalid_o,
    output logic [MUX-1:0]             pAcy1_o,
    output logic                       pErr_o
);

    localparam int COLUMN  = column_count(TWORD_WIDTH, MUX);
    localparam int PH_W    = (MUX > 1) ? $clog2(MUX) : 1;
    localparam int CNT_MAX = (WE_CYCLES > RD_LAT) ? WE_CYCLES : RD_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(MUX - 1);
    localparam logic [CNT_W-1:0] WE_TC   = CNT_W'(WE_CYCLES);
    localparam logic [CNT_W-1:0] RD_TC   = CNT_W'(RD_LAT);

    col_state_e             state;
    logic [MUX-1:0]         acy_q;
    logic [TWORD_WIDTH-1:0] cw_q;
    logic [PH_W-1:0]        ph_cnt;
    logic [CNT_W-1:0]       cyc_cnt;

    logic [PH_W-1:0]        ph_next;
    logic [MUX-1:0]         ph_next_oh;
    logic                   req_bad;
    logic [MUX-1:0]         map_phase;
    logic [TWORD_WIDTH-1:0] map_cw;
    logic [COLUMN-1:0]      map_mask;
    logic [COLUMN-1:0]      map_data;
    logic [TWORD_WIDTH-1:0] map_word;

    // The mapper always looks at the phase that will be driven next cycle,
    // so every array-facing output can be taken straight into a register.
    always_comb begin
        ph_next    = ph_cnt + PH_W'(1);
        ph_next_oh = MUX'(1) << ph_next;
        req_bad    = (pMode_i == MODE_RSVD) ||
                     ((pMode_i != MODE_BURST) && !is_onehot(ONEHOT_MAX'(pAcy_i)));
        map_phase  = acy_q;
        map_cw     = cw_q;
        case (state)
            ST_IDLE: begin
                map_cw    = pCodeword_i;
                map_phase = (pMode_i == MODE_BURST) ? MUX'(1) : pAcy_i;
            end
            ST_BURST: begin
                if (cyc_cnt == WE_TC) map_phase = ph_next_oh;
            end
            default: ;
        endcase
    end

    epl_col_mux_map #(
        .TWORD_WIDTH (TWORD_WIDTH),
        .MUX         (MUX)
    ) u_mux_map (
        .phase    (map_phase),
        .codeword (map_cw),
        .col_in   (pDo_i),
        .col_mask (map_mask),
        .col_data (map_data),
        .gather   (map_word)
    );

    always_ff @(posedge pClk_i or negedge nRst_i) begin
        if (!nRst_i) begin
            state     <= ST_IDLE;
            acy_q     <= '0;
            cw_q      <= '0;
            ph_cnt    <= '0;
            cyc_cnt   <= '0;
            pReady_o  <= 1'b0;
            pWe_o     <= '0;
            pDi_o     <= '0;
            pRe_o     <= '0;
            pRdata_o  <= '0;
            pRvalid_o <= 1'b0;
            pAcy1_o   <= '0;
            pErr_o    <= 1'b0;
        end else begin
            pErr_o    <= 1'b0;
            pRvalid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pValid_i && pReady_o) begin
                        if (req_bad) begin
                            pErr_o <= 1'b1;
                        end else begin
                            acy_q    <= map_phase;
                            cw_q     <= pCodeword_i;
                            pAcy1_o  <= map_phase;
                            ph_cnt   <= '0;
                            cyc_cnt  <= CNT_W'(1);
                            pReady_o <= 1'b0;
                            if (pMode_i == MODE_RD) begin
                                state <= ST_READ;
                                pRe_o <= map_mask;
                            end else begin
                                state <= (pMode_i == MODE_BURST) ? ST_BURST : ST_WRITE;
                                pWe_o <= map_mask;
                                pDi_o <= map_data;
                            end
                        end
                    end else begin
                        pReady_o <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (cyc_cnt == WE_TC) begin
                        state    <= ST_IDLE;
                        cyc_cnt  <= '0;
                        pWe_o    <= '0;
                        pDi_o    <= '0;
                        pReady_o <= 1'b1;
                    end else begin
                        cyc_cnt <= cyc_cnt + CNT_W'(1);
                    end
                end
                ST_BURST: begin
                    if (cyc_cnt != WE_TC) begin
                        cyc_cnt <= cyc_cnt + CNT_W'(1);
                    end else if (ph_cnt == PH_LAST) begin
                        state    <= ST_IDLE;
                        cyc_cnt  <= '0;
                        ph_cnt   <= '0;
                        pWe_o    <= '0;
                        pDi_o    <= '0;
                        pReady_o <= 1'b1;
                    end else begin
                        ph_cnt  <= ph_next;
                        cyc_cnt <= CNT_W'(1);
                        acy_q   <= map_phase;
                        pAcy1_o <= map_phase;
                        pWe_o   <= map_mask;
                        pDi_o   <= map_data;
                    end
                end
                ST_READ: begin
                    if (cyc_cnt == RD_TC) begin
                        state     <= ST_IDLE;
                        cyc_cnt   <= '0;
                        pRe_o     <= '0;
                        pRdata_o  <= map_word;
                        pRvalid_o <= 1'b1;
                        pReady_o  <= 1'b1;
                    end else begin
                        cyc_cnt <= cyc_cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_epl_column_access_seq.sv
// Directed bench for epl_column_access_seq: a MUX=4/WE=2 instance and a
// MUX=2/WE=1 instance driven with hand-computed vectors.
module tb_epl_column_access_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Instance A: TWORD_WIDTH=8, MUX=4, WE_CYCLES=2, RD_LAT=2
    logic        a_valid, a_ready, a_rvalid, a_err;
    logic [1:0]  a_mode;
    logic [3:0]  a_acy, a_acy1;
    logic [7:0]  a_cw, a_rdata;
    logic [31:0] a_we, a_di, a_re, a_do;

    // Instance B: TWORD_WIDTH=8, MUX=2, WE_CYCLES=1, RD_LAT=2
    logic        b_valid, b_ready, b_rvalid, b_err;
    logic [1:0]  b_mode;
    logic [1:0]  b_acy, b_acy1;
    logic [7:0]  b_cw, b_rdata;
    logic [15:0] b_we, b_di, b_re, b_do;

    epl_column_access_seq #(
        .TWORD_WIDTH (8), .MUX (4), .WE_CYCLES (2), .RD_LAT (2)
    ) dut_a (
        .pClk_i (clk), .nRst_i (rst_n),
        .pValid_i (a_valid), .pReady_o (a_ready), .pMode_i (a_mode),
        .pAcy_i (a_acy), .pCodeword_i (a_cw),
        .pWe_o (a_we), .pDi_o (a_di), .pRe_o (a_re), .pDo_i (a_do),
        .pRdata_o (a_rdata), .pRvalid_o (a_rvalid), .pAcy1_o (a_acy1), .pErr_o (a_err)
    );

    epl_column_access_seq #(
        .TWORD_WIDTH (8), .MUX (2), .WE_CYCLES (1), .RD_LAT (2)
    ) dut_b (
        .pClk_i (clk), .nRst_i (rst_n),
        .pValid_i (b_valid), .pReady_o (b_ready), .pMode_i (b_mode),
        .pAcy_i (b_acy), .pCodeword_i (b_cw),
        .pWe_o (b_we), .pDi_o (b_di), .pRe_o (b_re), .pDo_i (b_do),
        .pRdata_o (b_rdata), .pRvalid_o (b_rvalid), .pAcy1_o (b_acy1), .pErr_o (b_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request on A for exactly one accepting cycle; returns in N+1.
    task automatic a_req(input logic [1:0] mode, input logic [3:0] acy, input logic [7:0] cw);
        a_valid = 1'b1; a_mode = mode; a_acy = acy; a_cw = cw;
        step();
        a_valid = 1'b0;
    endtask

    task automatic b_req(input logic [1:0] mode, input logic [1:0] acy, input logic [7:0] cw);
        b_valid = 1'b1; b_mode = mode; b_acy = acy; b_cw = cw;
        step();
        b_valid = 1'b0;
    endtask

    initial begin
        a_valid = 0; a_mode = 0; a_acy = 0; a_cw = 0; a_do = 0;
        b_valid = 0; b_mode = 0; b_acy = 0; b_cw = 0; b_do = 0;
        #1;
        chk("rst_ready", a_ready, 0);
        chk("rst_we", a_we, 0);
        chk("rst_acy1", a_acy1, 0);
        step(); step();
        #3 rst_n = 1'b1;
        step();
        chk("rel_ready_a", a_ready, 1);
        chk("rel_ready_b", b_ready, 1);

        // 1: write A5 at phase 1 -> columns 1,9,21,29 carry data
        a_req(2'b00, 4'b0010, 8'hA5);
        for (int c = 0; c < 2; c++) begin
            chk("wr_we", a_we, 32'h2222_2222);
            chk("wr_di", a_di, 32'h2020_0202);
            chk("wr_acy1", a_acy1, 4'b0010);
            chk("wr_ready", a_ready, 0);
            chk("wr_re", a_re, 0);
            step();
        end
        chk("wr_end_we", a_we, 0);
        chk("wr_end_di", a_di, 0);
        chk("wr_end_ready", a_ready, 1);

        // 2: read phase 3, columns 7,15,31 high -> bits 1,3,7
        a_do = 32'h8000_8080;
        a_req(2'b01, 4'b1000, 8'h00);
        for (int c = 0; c < 2; c++) begin
            chk("rd_re", a_re, 32'h8888_8888);
            chk("rd_we", a_we, 0);
            chk("rd_rvalid", a_rvalid, 0);
            step();
        end
        chk("rd_rvalid_pulse", a_rvalid, 1);
        chk("rd_rdata", a_rdata, 8'h8A);
        chk("rd_re_off", a_re, 0);
        a_do = 32'h0;
        step();
        chk("rd_rvalid_drop", a_rvalid, 0);
        chk("rd_rdata_hold", a_rdata, 8'h8A);

        // 3: burst FF walks phases 0..3, two cycles each
        a_req(2'b10, 4'b0000, 8'hFF);
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 2; c++) begin
                chk("bu_we", a_we, 32'h1111_1111 << k);
                chk("bu_di", a_di, 32'h1111_1111 << k);
                chk("bu_acy1", a_acy1, 4'b0001 << k);
                step();
            end
        end
        chk("bu_end_we", a_we, 0);
        chk("bu_end_ready", a_ready, 1);
        chk("bu_acy1_hold", a_acy1, 4'b1000);

        // 4: rejected requests
        a_req(2'b00, 4'b0110, 8'h5A);
        chk("err_twohot", a_err, 1);
        chk("err_twohot_we", a_we, 0);
        chk("err_twohot_ready", a_ready, 1);
        step();
        chk("err_pulse_drop", a_err, 0);
        a_req(2'b11, 4'b0001, 8'h5A);
        chk("err_rsvd", a_err, 1);
        chk("err_rsvd_re", a_re, 0);
        chk("err_rsvd_ready", a_ready, 1);
        a_req(2'b01, 4'b0000, 8'h00);
        chk("err_zero_acy", a_err, 1);
        chk("err_zero_re", a_re, 0);
        chk("err_acy1_kept", a_acy1, 4'b1000);
        step();

        // 5: reset during burst phase 2
        a_req(2'b10, 4'b0000, 8'hC3);
        step(); step(); step(); step();
        chk("rb_phase2", a_we, 32'h4444_4444);
        #2 rst_n = 1'b0;
        #1;
        chk("rb_we_async", a_we, 0);
        chk("rb_di_async", a_di, 0);
        chk("rb_ready_async", a_ready, 0);
        chk("rb_acy1_async", a_acy1, 0);
        #2 rst_n = 1'b1;
        step();
        chk("rb_ready_back", a_ready, 1);
        chk("rb_no_we", a_we, 0);
        a_req(2'b00, 4'b0001, 8'h3C);
        chk("rb_wr_we", a_we, 32'h1111_1111);
        chk("rb_wr_di", a_di, 32'h0011_1100);
        step(); step();
        chk("rb_wr_done", a_we, 0);

        // 6: MUX=2, WE_CYCLES=1, valid held into the busy cycle
        b_valid = 1'b1; b_mode = 2'b00; b_acy = 2'b01; b_cw = 8'hA5;
        step();
        chk("b_wr_we", b_we, 16'h5555);
        chk("b_wr_di", b_di, 16'h4411);
        chk("b_wr_ready", b_ready, 0);
        step();
        b_valid = 1'b0;
        chk("b_wr_end_we", b_we, 0);
        chk("b_wr_end_ready", b_ready, 1);
        step();
        chk("b_no_double", b_we, 0);

        b_do = 16'h8002;
        b_req(2'b01, 2'b10, 8'h00);
        chk("b_rd_re1", b_re, 16'hAAAA);
        step();
        chk("b_rd_re2", b_re, 16'hAAAA);
        step();
        chk("b_rd_rvalid", b_rvalid, 1);
        chk("b_rd_rdata", b_rdata, 8'h81);
        b_do = 16'h0;
        step();

        b_req(2'b10, 2'b00, 8'hFF);
        chk("b_bu_ph0", b_we, 16'h5555);
        chk("b_bu_acy0", b_acy1, 2'b01);
        step();
        chk("b_bu_ph1", b_we, 16'hAAAA);
        chk("b_bu_acy1", b_acy1, 2'b10);
        step();
        chk("b_bu_end", b_we, 0);
        chk("b_bu_ready", b_ready, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
